// File: rtl/usb_pkg.sv
// rtl/usb_pkg.sv - shared encodings and constants for the full-speed USB transmitter
package usb_pkg;

    typedef enum logic [2:0] {
        PKT_NONE  = 3'd0,
        PKT_DATA0 = 3'd1,
        PKT_DATA1 = 3'd2,
        PKT_ACK   = 3'd3,
        PKT_NAK   = 3'd4,
        PKT_STALL = 3'd5
    } tx_packet_e;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [7:0]  SYNC_BYTE      = 8'h80;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    // Bit-reversed polynomial, for a register shifted right because data goes out LSB first.
    localparam logic [15:0] CRC16_POLY_REV = 16'hA001;
    localparam logic [15:0] CRC16_INIT     = 16'hFFFF;

    typedef enum logic [1:0] {LINE_J, LINE_K, LINE_SE0} line_e;

    // What the encoder should put on the line at its next bit boundary.
    typedef enum logic [1:0] {SYM_BIT, SYM_SE0, SYM_J, SYM_IDLE} sym_e;

    function automatic logic [3:0] pid_for(input logic [2:0] pkt);
        case (pkt)
            PKT_DATA0: return PID_DATA0;
            PKT_DATA1: return PID_DATA1;
            PKT_ACK:   return PID_ACK;
            PKT_NAK:   return PID_NAK;
            PKT_STALL: return PID_STALL;
            default:   return 4'h0;
        endcase
    endfunction

endpackage

// File: rtl/usb_tx_encoder.sv
// rtl/usb_tx_encoder.sv - bit timer, bit stuffing and NRZI line driver
module usb_tx_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_i,
    input  logic [1:0] sym_i,
    input  logic       bit_i,
    output logic       take_o,
    output logic       active_o,
    output logic       dp_o,
    output logic       dm_o
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    logic [TW-1:0] timer_q;
    logic [2:0]    ones_q;
    logic          running_q;
    logic          nrzi_q;
    logic          dp_q;
    logic          dm_q;
    logic          boundary;
    logic          stuff;
    sym_e          sym;

    assign sym      = sym_e'(sym_i);
    assign boundary = running_q ? (timer_q == TW'(CLKS_PER_BIT - 1)) : start_i;
    // A pending stuff bit pre-empts whatever symbol is offered, EOP included.
    assign stuff    = running_q && (ones_q == 3'd6);
    assign take_o   = boundary && !stuff;
    assign active_o = running_q;
    assign dp_o     = dp_q;
    assign dm_o     = dm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            running_q <= 1'b0;
            timer_q   <= '0;
            ones_q    <= '0;
            nrzi_q    <= 1'b1;
            dp_q      <= 1'b1;
            dm_q      <= 1'b0;
        end else begin
            if (running_q && !boundary) begin
                timer_q <= timer_q + 1'b1;
            end else begin
                timer_q <= '0;
            end
            if (boundary) begin
                running_q <= 1'b1;
                if (stuff || (sym == SYM_BIT && !bit_i)) begin
                    nrzi_q <= ~nrzi_q;
                    dp_q   <= ~nrzi_q;
                    dm_q   <= nrzi_q;
                    ones_q <= '0;
                end else if (sym == SYM_BIT) begin
                    ones_q <= ones_q + 1'b1;
                end else if (sym == SYM_SE0) begin
                    dp_q   <= 1'b0;
                    dm_q   <= 1'b0;
                    ones_q <= '0;
                end else begin
                    running_q <= (sym == SYM_J);
                    nrzi_q    <= 1'b1;
                    dp_q      <= 1'b1;
                    dm_q      <= 1'b0;
                    ones_q    <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - full-speed USB packet transmitter: packet FSM, byte shifter and CRC16
module usb_tx
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 9,
    parameter int MAX_PAYLOAD  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [2:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       tx_transfer_active,
    output logic       tx_error,
    output logic       dp_out,
    output logic       dm_out
);

    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_PID, S_DATA, S_CRC, S_EOP_SE0, S_EOP_J} state_e;

    state_e      state_q;
    logic [15:0] shift_q;
    logic [4:0]  bit_cnt_q;
    logic [6:0]  byte_cnt_q;
    logic [15:0] crc_q;
    logic [3:0]  pid_q;
    logic        is_data_q;
    logic        error_q;
    logic        pop_q;

    logic        req_data;
    logic        req_ok;
    logic        enc_start;
    logic        take;
    logic        bit_out;
    logic        last_bit;
    logic [15:0] crc_d;
    sym_e        sym;

    assign req_data  = (tx_packet == PKT_DATA0) || (tx_packet == PKT_DATA1);
    assign req_ok    = (tx_packet >= 3'd1) && (tx_packet <= 3'd5) &&
                       !(req_data && (buffer_occupancy > 7'(MAX_PAYLOAD)));
    assign enc_start = (state_q == S_IDLE) && tx_start && req_ok;
    // The first sync bit must reach the encoder in the same cycle as the request.
    assign bit_out   = (state_q == S_IDLE) ? SYNC_BYTE[0] : shift_q[0];
    assign last_bit  = (bit_cnt_q == 5'd1);
    assign crc_d     = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ shift_q[0]) ? CRC16_POLY_REV : 16'h0000);

    always_comb begin
        sym = SYM_BIT;
        case (state_q)
            S_EOP_SE0: sym = SYM_SE0;
            S_EOP_J:   sym = (bit_cnt_q == 5'd2) ? SYM_J : SYM_IDLE;
            default:   sym = SYM_BIT;
        endcase
    end

    usb_tx_encoder #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_encoder (
        .clk      (clk),
        .rst      (rst),
        .start_i  (enc_start),
        .sym_i    (sym),
        .bit_i    (bit_out),
        .take_o   (take),
        .active_o (tx_transfer_active),
        .dp_o     (dp_out),
        .dm_o     (dm_out)
    );

    assign get_tx_packet_data = pop_q;
    assign tx_error           = error_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            crc_q      <= CRC16_INIT;
            pid_q      <= '0;
            is_data_q  <= 1'b0;
            error_q    <= 1'b0;
            pop_q      <= 1'b0;
        end else begin
            pop_q <= 1'b0;
            if (take && (state_q inside {S_SYNC, S_PID, S_DATA, S_CRC})) begin
                shift_q   <= shift_q >> 1;
                bit_cnt_q <= bit_cnt_q - 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (tx_start) begin
                        if (req_ok) begin
                            error_q    <= 1'b0;
                            state_q    <= S_SYNC;
                            shift_q    <= {9'h000, SYNC_BYTE[7:1]};
                            bit_cnt_q  <= 5'd7;
                            pid_q      <= pid_for(tx_packet);
                            is_data_q  <= req_data;
                            byte_cnt_q <= buffer_occupancy;
                            crc_q      <= CRC16_INIT;
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                S_SYNC: begin
                    if (take && last_bit) begin
                        shift_q   <= {8'h00, ~pid_q, pid_q};
                        bit_cnt_q <= 5'd8;
                        state_q   <= S_PID;
                    end
                end
                S_PID: begin
                    if (take && last_bit) begin
                        if (!is_data_q) begin
                            state_q   <= S_EOP_SE0;
                            bit_cnt_q <= 5'd2;
                        end else if (byte_cnt_q != 7'd0) begin
                            shift_q    <= {8'h00, tx_packet_data};
                            byte_cnt_q <= byte_cnt_q - 1'b1;
                            pop_q      <= 1'b1;
                            bit_cnt_q  <= 5'd8;
                            state_q    <= S_DATA;
                        end else begin
                            shift_q   <= ~crc_q;
                            bit_cnt_q <= 5'd16;
                            state_q   <= S_CRC;
                        end
                    end
                end
                S_DATA: begin
                    if (take) begin
                        crc_q <= crc_d;
                        if (last_bit) begin
                            if (byte_cnt_q != 7'd0) begin
                                shift_q    <= {8'h00, tx_packet_data};
                                byte_cnt_q <= byte_cnt_q - 1'b1;
                                pop_q      <= 1'b1;
                                bit_cnt_q  <= 5'd8;
                            end else begin
                                shift_q   <= ~crc_d;
                                bit_cnt_q <= 5'd16;
                                state_q   <= S_CRC;
                            end
                        end
                    end
                end
                S_CRC: begin
                    if (take && last_bit) begin
                        state_q   <= S_EOP_SE0;
                        bit_cnt_q <= 5'd2;
                    end
                end
                S_EOP_SE0: begin
                    if (take) begin
                        if (last_bit) begin
                            state_q   <= S_EOP_J;
                            bit_cnt_q <= 5'd2;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                        end
                    end
                end
                S_EOP_J: begin
                    // First take drives the J bit; the second ends it and releases the line.
                    if (take) begin
                        if (bit_cnt_q == 5'd2) begin
                            bit_cnt_q <= 5'd1;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx.sv
// tb/tb_usb_tx.sv - self-checking bench for usb_tx: vector table, random packets, corner sequences
module tb_usb_tx;

    localparam logic [1:0] LJ = 2'b10, LK = 2'b01, LSE0 = 2'b00;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start = 1'b0;
    logic [2:0] tx_packet = 3'd0;
    logic [6:0] buffer_occupancy = 7'd0;
    logic [7:0] tx_packet_data = 8'h00;
    logic       get_tx_packet_data, tx_transfer_active, tx_error, dp_out, dm_out;

    int checks = 0;
    int errors = 0;
    int pops = 0;
    logic [7:0] fifo[$];
    logic [7:0] pay_q[$];
    logic [1:0] trace[$];
    bit         mb_q[$];
    bit         gb_q[$];

    typedef struct {
        logic [2:0] pkt;
        logic [6:0] occ;
        int         mode;
        bit         exp_err;
        logic [7:0] exp_pid;
    } vec_t;

    usb_tx dut (
        .clk                (clk),
        .rst                (rst),
        .tx_start           (tx_start),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_transfer_active (tx_transfer_active),
        .tx_error           (tx_error),
        .dp_out             (dp_out),
        .dm_out             (dm_out)
    );

    always #5 clk = ~clk;

    // FIFO model and line recorder, both away from the active edge.
    always @(negedge clk) begin
        if (get_tx_packet_data) begin
            pops++;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        tx_packet_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
        if (tx_transfer_active) trace.push_back({dp_out, dm_out});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (tx_transfer_active && n < 8000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " finished"}, tx_transfer_active, 0);
    endtask

    task automatic check_packet(input string tag, input logic [7:0] pid, input bit is_data);
        logic [15:0] c;
        logic [7:0]  byte_v;
        logic [1:0]  prev, s;
        int ones, nstuff, nsym, bad_edge, stuffed, bad_stuff, run, maxrun, k, mism;
        bit b, eop_ok;
        mb_q.delete();
        gb_q.delete();
        for (int i = 0; i < 8; i++) mb_q.push_back(i == 7);
        for (int i = 0; i < 8; i++) mb_q.push_back(pid[i]);
        c = 16'hFFFF;
        foreach (pay_q[j]) begin
            for (int i = 0; i < 8; i++) begin
                b = pay_q[j][i];
                mb_q.push_back(b);
                c = (c[15] ^ b) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
            end
        end
        if (is_data) for (int i = 15; i >= 0; i--) mb_q.push_back(!c[i]);
        ones = 0;
        nstuff = 0;
        foreach (mb_q[i]) begin
            if (mb_q[i]) begin
                ones++;
                if (ones == 6) begin
                    nstuff++;
                    ones = 0;
                end
            end else ones = 0;
        end
        chk({tag, " active length"}, trace.size(), (mb_q.size() + nstuff + 3) * 9);
        chk({tag, " fifo pops"}, pops, pay_q.size());

        nsym = trace.size() / 9;
        bad_edge = 0;
        for (int i = 0; i < nsym * 9; i++) if (trace[i] !== trace[(i / 9) * 9]) bad_edge++;
        chk({tag, " mid-bit line changes"}, bad_edge, 0);

        prev = LJ; ones = 0; stuffed = 0; bad_stuff = 0; run = 0; maxrun = 0; k = 0;
        while (k < nsym && trace[k * 9 + 4] != LSE0) begin
            s = trace[k * 9 + 4];
            b = (s == prev);
            run = b ? run + 1 : 1;
            if (run > maxrun) maxrun = run;
            prev = s;
            if (ones == 6) begin
                stuffed++;
                if (b) bad_stuff++;
                ones = 0;
            end else begin
                gb_q.push_back(b);
                ones = b ? ones + 1 : 0;
            end
            k++;
        end
        chk({tag, " stuffed bits"}, stuffed, nstuff);
        chk({tag, " stuff bits are zero"}, bad_stuff, 0);
        chk({tag, " longest line run <= 7"}, maxrun <= 7, 1);
        eop_ok = 0;
        if (k + 3 == nsym)
            eop_ok = (trace[k * 9 + 4] == LSE0) && (trace[(k + 1) * 9 + 4] == LSE0) &&
                     (trace[(k + 2) * 9 + 4] == LJ);
        chk({tag, " eop se0 se0 j"}, eop_ok, 1);

        chk({tag, " decoded bit count"}, gb_q.size(), mb_q.size());
        mism = 0;
        for (int i = 0; i < gb_q.size() && i < mb_q.size(); i++) if (gb_q[i] != mb_q[i]) mism++;
        chk({tag, " decoded bit errors"}, mism, 0);
        byte_v = 8'h00;
        if (gb_q.size() >= 16) for (int i = 0; i < 8; i++) byte_v[i] = gb_q[8 + i];
        chk({tag, " pid byte"}, byte_v, pid);
        if (is_data) begin
            mism = 0;
            foreach (pay_q[j]) begin
                byte_v = 8'h00;
                for (int i = 0; i < 8; i++) if (16 + 8 * j + i < gb_q.size()) byte_v[i] = gb_q[16 + 8 * j + i];
                if (byte_v != pay_q[j]) mism++;
            end
            chk({tag, " payload bytes"}, mism, 0);
            c = 16'hFFFF;
            for (int i = 16; i < gb_q.size(); i++)
                c = (c[15] ^ gb_q[i]) ? ({c[14:0], 1'b0} ^ 16'h8005) : {c[14:0], 1'b0};
            chk({tag, " crc residual"}, c, 16'h800D);
        end
    endtask

    task automatic pulse_start(input logic [2:0] pkt, input logic [6:0] occ);
        @(negedge clk);
        tx_packet = pkt;
        buffer_occupancy = occ;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tx_packet = 3'd0;
        buffer_occupancy = 7'd0;
    endtask

    task automatic run_req(input string tag, input logic [2:0] pkt, input logic [6:0] occ,
                           input bit exp_err, input logic [7:0] pid);
        bit is_data;
        is_data = (pkt == 3'd1) || (pkt == 3'd2);
        if (!exp_err) foreach (pay_q[i]) fifo.push_back(pay_q[i]);
        @(negedge clk);
        trace.delete();
        pops = 0;
        pulse_start(pkt, occ);
        chk({tag, " tx_error"}, tx_error, exp_err);
        chk({tag, " active after start"}, tx_transfer_active, !exp_err);
        if (exp_err) begin
            repeat (20) @(negedge clk);
            chk({tag, " lines stay J"}, {tx_transfer_active, dp_out, dm_out}, 3'b010);
            chk({tag, " no pops"}, pops, 0);
        end else begin
            chk({tag, " first symbol K"}, {dp_out, dm_out}, LK);
            wait_idle(tag);
            check_packet(tag, pid, is_data);
        end
    endtask

    initial begin
        vec_t vecs[11];
        logic [1:0] ack_exp[19];
        logic [3:0] pid_nib[6];
        int mism;
        logic [2:0] rp;
        int n;

        vecs = '{
            '{3'd3, 7'd0,  0, 1'b0, 8'hD2},
            '{3'd1, 7'd4,  0, 1'b0, 8'hC3},
            '{3'd2, 7'd4,  1, 1'b0, 8'h4B},
            '{3'd1, 7'd0,  0, 1'b0, 8'hC3},
            '{3'd6, 7'd0,  0, 1'b1, 8'h00},
            '{3'd1, 7'd65, 0, 1'b1, 8'h00},
            '{3'd4, 7'd0,  0, 1'b0, 8'h5A},
            '{3'd7, 7'd0,  0, 1'b1, 8'h00},
            '{3'd0, 7'd0,  0, 1'b1, 8'h00},
            '{3'd5, 7'd0,  0, 1'b0, 8'h1E},
            '{3'd2, 7'd64, 2, 1'b0, 8'h4B}
        };
        ack_exp = '{LK, LJ, LK, LJ, LK, LJ, LK, LK, LJ, LJ, LK, LJ, LJ, LK, LK, LK, LSE0, LSE0, LJ};
        pid_nib = '{4'h0, 4'h3, 4'hB, 4'h2, 4'hA, 4'hE};

        rst = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset outputs", {dp_out, dm_out, tx_transfer_active, tx_error, get_tx_packet_data}, 5'b10000);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            pay_q.delete();
            if (!vecs[v].exp_err && (vecs[v].pkt == 3'd1 || vecs[v].pkt == 3'd2))
                for (int i = 0; i < vecs[v].occ; i++)
                    pay_q.push_back(vecs[v].mode == 0 ? 8'(i) : vecs[v].mode == 1 ? 8'hFF : 8'($urandom));
            run_req($sformatf("vec%0d", v), vecs[v].pkt, vecs[v].occ, vecs[v].exp_err, vecs[v].exp_pid);
            if (vecs[v].pkt == 3'd3) begin
                mism = 0;
                if (trace.size() < 171) mism = 19;
                else for (int i = 0; i < 19; i++) if (trace[i * 9 + 4] !== ack_exp[i]) mism++;
                chk("ack line sequence", mism, 0);
            end
        end

        for (int r = 0; r < 6; r++) begin
            rp = 3'($urandom_range(1, 5));
            n = (rp <= 3'd2) ? $urandom_range(0, 16) : 0;
            pay_q.delete();
            for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
            run_req($sformatf("rand%0d", r), rp, 7'(n), 1'b0, {~pid_nib[rp], pid_nib[rp]});
        end

        // Requests while a packet is on the wire must be ignored.
        pay_q = '{8'hA5, 8'h5A};
        foreach (pay_q[i]) fifo.push_back(pay_q[i]);
        @(negedge clk);
        trace.delete();
        pops = 0;
        pulse_start(3'd1, 7'd2);
        repeat (40) @(negedge clk);
        pulse_start(3'd6, 7'd0);
        chk("busy illegal start no error", tx_error, 0);
        repeat (30) @(negedge clk);
        pulse_start(3'd3, 7'd0);
        wait_idle("busy");
        check_packet("busy", 8'hC3, 1'b1);

        // Reset in the middle of a packet: J at once, and no EOP follows.
        pay_q.delete();
        pulse_start(3'd4, 7'd0);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid-packet reset lines J", {tx_transfer_active, dp_out, dm_out}, 3'b010);
        rst = 1'b0;
        trace.delete();
        repeat (200) @(negedge clk);
        chk("no activity after reset", trace.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
